// File: rtl/exu_issue_ctrl_if.sv
// exu_issue_ctrl_if: decode, LSU, GPR write-back, redirect and exception signals of the issue controller
interface exu_issue_ctrl_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            inst_vld;
  logic            inst_rdy;
  logic [1:0]      inst_cls;
  logic [4:0]      inst_rd;
  logic [PC_W-1:0] inst_pc;
  logic [XLEN-1:0] alu_dst;
  logic [XLEN-1:0] st_data;
  logic            lsu_req_vld;
  logic            lsu_req_rdy;
  logic            lsu_req_we;
  logic [XLEN-1:0] lsu_req_addr;
  logic [XLEN-1:0] lsu_req_wdata;
  logic            lsu_rsp_vld;
  logic            lsu_rsp_err;
  logic [XLEN-1:0] lsu_rsp_data;
  logic            gpr_wen;
  logic [4:0]      gpr_waddr;
  logic [XLEN-1:0] gpr_wdata;
  logic            redir_vld;
  logic [PC_W-1:0] redir_pc;
  logic            exc_vld;
  logic            exc_tmo;
  logic            retire_vld;
  modport master (
    input  inst_vld, inst_cls, inst_rd, inst_pc, alu_dst, st_data,
    input  lsu_req_rdy, lsu_rsp_vld, lsu_rsp_err, lsu_rsp_data,
    output inst_rdy, lsu_req_vld, lsu_req_we, lsu_req_addr, lsu_req_wdata,
    output gpr_wen, gpr_waddr, gpr_wdata, redir_vld, redir_pc, exc_vld, exc_tmo, retire_vld
  );
  modport slave (
    output inst_vld, inst_cls, inst_rd, inst_pc, alu_dst, st_data,
    output lsu_req_rdy, lsu_rsp_vld, lsu_rsp_err, lsu_rsp_data,
    input  inst_rdy, lsu_req_vld, lsu_req_we, lsu_req_addr, lsu_req_wdata,
    input  gpr_wen, gpr_waddr, gpr_wdata, redir_vld, redir_pc, exc_vld, exc_tmo, retire_vld
  );
endinterface

// File: rtl/exu_issue_ctrl.sv
// exu_issue_ctrl: execute-stage sequencing of ALU write-back, jumps and LSU transactions
module exu_issue_ctrl #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter int TMO_CYC = 64
) (
  input logic              clk,
  input logic              rst_n,
  exu_issue_ctrl_if.master bus
);
  localparam int CW = $clog2(TMO_CYC) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt;
  logic            r_ld;
  logic [4:0]      r_rd;
  logic            r_req_vld, w_req_vld, r_req_we, w_req_we;
  logic [XLEN-1:0] r_req_addr, w_req_addr, r_req_wdata, w_req_wdata;
  logic            r_gpr_wen, w_gpr_wen;
  logic [4:0]      r_gpr_waddr, w_gpr_waddr;
  logic [XLEN-1:0] r_gpr_wdata, w_gpr_wdata;
  logic            r_redir_vld, w_redir_vld;
  logic [PC_W-1:0] r_redir_pc, w_redir_pc;
  logic            r_exc_vld, w_exc_vld, r_exc_tmo, w_exc_tmo;
  logic            r_retire_vld, w_retire_vld;
  logic            w_acc, w_mem, w_jmp, w_rsp, w_tmo;
  assign w_acc = bus.inst_vld & (r_state == IDLE);
  assign w_mem = (bus.inst_cls == 2'd1) | (bus.inst_cls == 2'd2);
  assign w_jmp = bus.inst_cls == 2'd3;
  assign w_rsp = (r_state == RSP) & bus.lsu_rsp_vld;
  assign w_tmo = (r_state == RSP) & !bus.lsu_rsp_vld & (r_cnt == TMO_LAST);
  // state register
  always_ff @(posedge clk)
    r_state <= !rst_n ? IDLE : w_state;
  // next state: memory ops walk REQ -> RSP, a response or timeout returns to IDLE
  always_comb begin
    w_state = r_state;
    case (r_state)
      IDLE:    w_state = (w_acc & w_mem) ? REQ : IDLE;
      REQ:     w_state = bus.lsu_req_rdy ? RSP : REQ;
      default: w_state = (w_rsp | w_tmo) ? IDLE : RSP;
    endcase
  end
  // response-wait counter and the destination info needed when the LSU answers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ld  <= 1'b0;
      r_rd  <= '0;
    end else begin
      r_cnt <= (r_state == REQ) ? '0 : (r_state == RSP && !bus.lsu_rsp_vld && r_cnt != TMO_LAST) ? r_cnt + CW'(1) : r_cnt;
      if (w_acc) begin
        r_ld <= bus.inst_cls == 2'd1;
        r_rd <= bus.inst_rd;
      end
    end
  end
  // next values of the registered outputs; a response beats a same-cycle timeout
  always_comb begin
    w_gpr_wen    = 1'b0;
    w_gpr_waddr  = r_gpr_waddr;
    w_gpr_wdata  = r_gpr_wdata;
    w_redir_vld  = 1'b0;
    w_redir_pc   = r_redir_pc;
    w_exc_vld    = 1'b0;
    w_exc_tmo    = r_exc_tmo;
    w_retire_vld = 1'b0;
    w_req_vld    = r_req_vld & !(r_state == REQ & bus.lsu_req_rdy);
    w_req_we     = r_req_we;
    w_req_addr   = r_req_addr;
    w_req_wdata  = r_req_wdata;
    if (w_acc & w_mem) begin
      w_req_vld   = 1'b1;
      w_req_we    = bus.inst_cls == 2'd2;
      w_req_addr  = bus.alu_dst;
      w_req_wdata = bus.st_data;
    end
    if (w_acc & !w_mem) begin
      w_gpr_wen    = bus.inst_rd != 5'd0;
      w_gpr_waddr  = bus.inst_rd;
      w_gpr_wdata  = w_jmp ? XLEN'(bus.inst_pc + PC_W'(4)) : bus.alu_dst;
      w_redir_vld  = w_jmp;
      w_redir_pc   = w_jmp ? {bus.alu_dst[PC_W-1:1], 1'b0} : r_redir_pc;
      w_retire_vld = 1'b1;
    end
    if (w_rsp) begin
      w_exc_vld    = bus.lsu_rsp_err;
      w_exc_tmo    = bus.lsu_rsp_err ? 1'b0 : r_exc_tmo;
      w_retire_vld = !bus.lsu_rsp_err;
      w_gpr_wen    = !bus.lsu_rsp_err & r_ld & (r_rd != 5'd0);
      w_gpr_waddr  = bus.lsu_rsp_err ? r_gpr_waddr : r_rd;
      w_gpr_wdata  = bus.lsu_rsp_err ? r_gpr_wdata : bus.lsu_rsp_data;
    end
    if (w_tmo) begin
      w_exc_vld = 1'b1;
      w_exc_tmo = 1'b1;
    end
  end
  // output registers; reset clears everything, dropping any in-flight instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gpr_wen    <= 1'b0;
      r_gpr_waddr  <= '0;
      r_gpr_wdata  <= '0;
      r_redir_vld  <= 1'b0;
      r_redir_pc   <= '0;
      r_exc_vld    <= 1'b0;
      r_exc_tmo    <= 1'b0;
      r_retire_vld <= 1'b0;
      r_req_vld    <= 1'b0;
      r_req_we     <= 1'b0;
      r_req_addr   <= '0;
      r_req_wdata  <= '0;
    end else begin
      r_gpr_wen    <= w_gpr_wen;
      r_gpr_waddr  <= w_gpr_waddr;
      r_gpr_wdata  <= w_gpr_wdata;
      r_redir_vld  <= w_redir_vld;
      r_redir_pc   <= w_redir_pc;
      r_exc_vld    <= w_exc_vld;
      r_exc_tmo    <= w_exc_tmo;
      r_retire_vld <= w_retire_vld;
      r_req_vld    <= w_req_vld;
      r_req_we     <= w_req_we;
      r_req_addr   <= w_req_addr;
      r_req_wdata  <= w_req_wdata;
    end
  end
  assign bus.inst_rdy      = r_state == IDLE;
  assign bus.lsu_req_vld   = r_req_vld;
  assign bus.lsu_req_we    = r_req_we;
  assign bus.lsu_req_addr  = r_req_addr;
  assign bus.lsu_req_wdata = r_req_wdata;
  assign bus.gpr_wen       = r_gpr_wen;
  assign bus.gpr_waddr     = r_gpr_waddr;
  assign bus.gpr_wdata     = r_gpr_wdata;
  assign bus.redir_vld     = r_redir_vld;
  assign bus.redir_pc      = r_redir_pc;
  assign bus.exc_vld       = r_exc_vld;
  assign bus.exc_tmo       = r_exc_tmo;
  assign bus.retire_vld    = r_retire_vld;
endmodule

// File: doc/exu_issue_ctrl.md
Name: exu_issue_ctrl

Overview:
Sequencing controller for the execute-stage datapath (ALU result, GPR write port, LSU port) of the RV32I core.
- Accepts one decoded instruction at a time from decode via valid/ready.
- Classifies each instruction as single-cycle ALU-class (incl. LUI/AUIPC/OP/OP-IMM), load, store or jump.
- Sequences LSU request/response, GPR write-back, PC redirect and retire.
- Flags bus errors and response timeouts as exceptions.

Parameters:
XLEN, 32, datapath/GPR width
PC_W, 32, PC width
TMO_CYC, 64, max cycles waiting for LSU response before timeout exception (>=2)

Ports:
clk  in  1  core clock
rst_n  in  1  reset; synchronous, active-low
inst_vld  in  1  decoded instruction valid
inst_rdy  out  1  controller can accept instruction
inst_cls  in  2  class: 0 ALU, 1 LOAD, 2 STORE, 3 JUMP
inst_rd  in  5  destination GPR index
inst_pc  in  PC_W  PC of instruction
alu_dst  in  XLEN  ALU result for current instruction (result / mem addr / jump target)
st_data  in  XLEN  store data (rs2 value)
lsu_req_vld  out  1  LSU request valid
lsu_req_rdy  in  1  LSU accepts request
lsu_req_we  out  1  1 store, 0 load
lsu_req_addr  out  XLEN  request address
lsu_req_wdata  out  XLEN  store data
lsu_rsp_vld  in  1  LSU response valid (1-cycle pulse)
lsu_rsp_err  in  1  response carries bus error
lsu_rsp_data  in  XLEN  load data
gpr_wen  out  1  GPR write enable
gpr_waddr  out  5  GPR write index
gpr_wdata  out  XLEN  GPR write data
redir_vld  out  1  PC redirect pulse
redir_pc  out  PC_W  redirect target
exc_vld  out  1  exception pulse (bus error / timeout)
exc_tmo  out  1  qualifies exc_vld: 1 timeout, 0 bus error
retire_vld  out  1  instruction completed pulse

Behaviour:
- All outputs are registered except inst_rdy (= state==IDLE).
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; all other outputs 0; timeout counter 0.
  - Reset mid-transaction drops the instruction: no write, no retire, lsu_req_vld deasserts next cycle.
- Handshake: accept occurs when inst_vld & inst_rdy. Inputs are sampled only on the accept cycle; address, data, rd and pc are latched.
- States: IDLE, REQ, RSP.
- IDLE, accept ALU: next cycle pulse gpr_wen (if rd!=0), gpr_waddr=rd, gpr_wdata=alu_dst, retire_vld=1. Stay IDLE (back-to-back ALU = 1 instr/cycle).
- IDLE, accept JUMP: next cycle:
  - gpr write of inst_pc+4 (mod 2^PC_W) if rd!=0;
  - redir_vld=1, redir_pc=alu_dst with bit0 cleared;
  - retire_vld=1.
- IDLE, accept LOAD/STORE: go to REQ; lsu_req_vld=1 next cycle, addr=alu_dst, we=(cls==STORE), wdata=st_data.
- REQ: hold all request fields stable while lsu_req_vld & !lsu_req_rdy. On lsu_req_rdy: drop lsu_req_vld next cycle, clear counter, go to RSP.
- RSP: counter increments each cycle without lsu_rsp_vld.
  - lsu_rsp_vld & !err: next cycle retire_vld=1, plus gpr write of lsu_rsp_data for LOAD with rd!=0; go IDLE.
  - lsu_rsp_vld & err: next cycle exc_vld=1, exc_tmo=0, no write, no retire; go IDLE.
  - counter reaches TMO_CYC-1 without response: next cycle exc_vld=1, exc_tmo=1, no retire; go IDLE.
  - Response and timeout on the same cycle: response wins.
  - lsu_rsp_vld outside RSP is ignored.
- gpr_wen, redir_vld, exc_vld and retire_vld are single-cycle pulses.
- exc_vld and retire_vld are mutually exclusive.
- rd==0: gpr_wen stays 0; retire still occurs.
- Counter width is $clog2(TMO_CYC)+1 and never wraps.

Test Plan:
- Reset, then ALU accept with rd=5, alu_dst=0x1234 -> next cycle gpr_wen=1, waddr=5, wdata=0x1234, retire_vld=1; three back-to-back ALU accepts give three consecutive retires.
- JUMP with pc=0x100, rd=1, alu_dst=0x205 -> gpr_wdata=0x104, redir_pc=0x204, redir_vld and retire_vld pulse once.
- LOAD rd=0 addr 0x80 with lsu_req_rdy low for 3 cycles, then rsp data 0xDEAD after 2 cycles:
  - request fields stable while stalled;
  - gpr_wen=0, retire_vld=1;
  - inst_rdy=0 throughout.
- STORE with rsp_err=1 -> exc_vld=1, exc_tmo=0, retire_vld=0, back to IDLE (inst_rdy=1).
- TMO_CYC=4, no response -> exc_vld with exc_tmo=1 exactly 4 cycles after the request is accepted; a late lsu_rsp_vld is ignored.
- rst_n low during RSP -> outputs 0 next cycle, no retire, clean accept afterwards.
